// File: rtl/apb_pkg.sv
// Shared types and default bus widths for the two-requester APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer updates only on acceptance.
// A lone requester always wins; on a tie the one not granted last wins.
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_d = last_q;
    if (accept && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // Reset points at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Arbitrates two requesters onto one APB master port, one transfer in flight.
// Accept at T, SETUP T+1, ACCESS T+2.., rsp pulse the first IDLE cycle after; requests wait while busy.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req_vld,
  output logic          r0_req_rdy,
  input  logic [AW-1:0] r0_req_addr,
  input  logic          r0_req_wr,
  input  logic [DW-1:0] r0_req_wdata,
  output logic          r0_rsp_vld,
  output logic [DW-1:0] r0_rsp_rdata,
  output logic          r0_rsp_err,
  input  logic          r1_req_vld,
  output logic          r1_req_rdy,
  input  logic [AW-1:0] r1_req_addr,
  input  logic          r1_req_wr,
  input  logic [DW-1:0] r1_req_wdata,
  output logic          r1_rsp_vld,
  output logic [DW-1:0] r1_rsp_rdata,
  output logic          r1_rsp_err,
  output logic          m_psel,
  output logic          m_penable,
  output logic [AW-1:0] m_paddr,
  output logic          m_pwrite,
  output logic [DW-1:0] m_pwdata,
  input  logic [DW-1:0] m_prdata,
  input  logic          m_pready,
  input  logic          m_pslverr
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rsp_vld_q, rsp_vld_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic          r0_err_q, r0_err_d, r1_err_q, r1_err_d;

  logic [1:0]    req;
  logic [1:0]    grant;
  logic          idle;
  logic          accept;
  logic          tmo;
  logic [DW-1:0] rdata_c;
  logic          err_c;

  assign req    = {r1_req_vld, r0_req_vld};
  assign idle   = (state_q == IDLE);
  assign accept = idle && (grant != 2'b00);

  apb_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // The grant only exists for an asserted request, so rdy implies vld.
  assign r0_req_rdy = idle && grant[0];
  assign r1_req_rdy = idle && grant[1];

  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT)) && !m_pready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    cnt_d      = cnt_q;
    rsp_vld_d  = 2'b00;
    r0_rdata_d = r0_rdata_q;
    r0_err_d   = r0_err_q;
    r1_rdata_d = r1_rdata_q;
    r1_err_d   = r1_err_q;
    rdata_c    = '0;
    err_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          owner_d  = grant[1];
          paddr_d  = grant[1] ? r1_req_addr  : r0_req_addr;
          pwrite_d = grant[1] ? r1_req_wr    : r0_req_wr;
          pwdata_d = grant[1] ? r1_req_wdata : r0_req_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CW'(1);
      end
      ACCESS: begin
        if (m_pready || tmo) begin
          // A timed-out transfer reports an error with zero data.
          rdata_c            = (m_pready && !pwrite_q) ? m_prdata : '0;
          err_c              = m_pready ? m_pslverr : 1'b1;
          state_d            = IDLE;
          cnt_d              = '0;
          rsp_vld_d[owner_q] = 1'b1;
          if (owner_q) begin
            r1_rdata_d = rdata_c;
            r1_err_d   = err_c;
          end else begin
            r0_rdata_d = rdata_c;
            r0_err_d   = err_c;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      cnt_q      <= '0;
      rsp_vld_q  <= 2'b00;
      r0_rdata_q <= '0;
      r0_err_q   <= 1'b0;
      r1_rdata_q <= '0;
      r1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      cnt_q      <= cnt_d;
      rsp_vld_q  <= rsp_vld_d;
      r0_rdata_q <= r0_rdata_d;
      r0_err_q   <= r0_err_d;
      r1_rdata_q <= r1_rdata_d;
      r1_err_q   <= r1_err_d;
    end
  end

  assign m_psel       = (state_q != IDLE);
  assign m_penable    = (state_q == ACCESS);
  assign m_paddr      = paddr_q;
  assign m_pwrite     = pwrite_q;
  assign m_pwdata     = pwdata_q;
  assign r0_rsp_vld   = rsp_vld_q[0];
  assign r1_rsp_vld   = rsp_vld_q[1];
  assign r0_rsp_rdata = r0_rdata_q;
  assign r0_rsp_err   = r0_err_q;
  assign r1_rsp_rdata = r1_rdata_q;
  assign r1_rsp_err   = r1_err_q;

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameters (name, default, meaning):
- TIMEOUT, 256: maximum ACCESS cycles; 0 disables the timeout.
- AW, 32: address width.
- DW, 32: data width.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- rN_req_vld, in, 1 (N=0,1): requester N transfer request.
- rN_req_rdy, out, 1: request accepted this cycle.
- rN_req_addr, in, AW: transfer address.
- rN_req_wr, in, 1: 1 = write, 0 = read.
- rN_req_wdata, in, DW: write data.
- rN_rsp_vld, out, 1: one-cycle completion pulse.
- rN_rsp_rdata, out, DW: read data.
- rN_rsp_err, out, 1: slave error or timeout.
- m_psel, out, 1: APB select, feeds the system APB decoder.
- m_penable, out, 1: APB enable.
- m_paddr, out, AW: APB address.
- m_pwrite, out, 1: APB direction.
- m_pwdata, out, DW: APB write data.
- m_prdata, in, DW: APB read data.
- m_pready, in, 1: APB ready.
- m_pslverr, in, 1: APB slave error.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, SETUP and ACCESS; at most one transfer is in flight.
REQ-004 rN_req_rdy SHALL be high only in IDLE, only for the granted requester, and only when that requester's rN_req_vld is high; acceptance is vld&rdy.
REQ-005 Arbitration SHALL be round-robin: a sole requester wins; on simultaneous requests, the requester not granted last wins; the last-grant pointer updates only on acceptance.
REQ-006 On acceptance, the block SHALL latch addr/wr/wdata and go to SETUP; m_psel=1, m_penable=0 in SETUP.
REQ-007 SETUP SHALL always go to ACCESS next cycle; m_psel=1, m_penable=1 in ACCESS.
REQ-008 m_paddr/m_pwrite/m_pwdata SHALL be stable from SETUP through the last ACCESS cycle.
REQ-009 m_psel/m_penable SHALL be 0 in IDLE; m_paddr/m_pwrite/m_pwdata hold their last values.
REQ-010 ACCESS with m_pready=1 SHALL complete the transfer:
- capture m_prdata (0 for writes) and m_pslverr;
- return to IDLE.
REQ-011 An ACCESS-cycle counter SHALL count from 1 in the first ACCESS cycle; if m_pready=0 in the TIMEOUT-th ACCESS cycle and TIMEOUT>0, the block SHALL complete with err=1, rdata=0, and return to IDLE.
REQ-012 m_pready=1 in the TIMEOUT-th cycle SHALL count as normal completion, not timeout.
REQ-013 rN_rsp_vld SHALL pulse for exactly one cycle, to the owner only, in the first IDLE cycle after completion.
REQ-014 rN_rsp_rdata/rN_rsp_err SHALL be valid with rN_rsp_vld and hold until the next response to that requester.
REQ-015 A new acceptance SHALL be allowed in the same cycle as rsp_vld.
REQ-016 Minimum latency SHALL be: accept at T, SETUP T+1, ACCESS T+2, rsp_vld T+3; back-to-back transfers run one every 3 cycles.
REQ-017 Deassertion of rN_req_vld before acceptance SHALL have no effect; m_pready and m_pslverr SHALL be ignored outside ACCESS.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state to IDLE; all outputs to 0;
- the counter to 0;
- the last-grant pointer to 1, so that r0 wins the first tie.
REQ-019 Reset during SETUP or ACCESS SHALL abort the transfer with no response pulse after reset release.

Structure
REQ-020 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the default AW/DW constants.
REQ-021 Two-way round-robin grant logic SHALL be a sub-module, apb_rr_arb2 (req[1:0], accept, grant[1:0]); the remainder stays flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- r0 read 0x8000_0010, pready=1 at first ACCESS, prdata=0xDEAD_BEEF -> psel T+1, penable T+2, r0_rsp_vld T+3, rdata 0xDEAD_BEEF, err 0.
- r0 and r1 request together, three times -> grants r0, r1, r0; each response goes to its owner only.
- r1 write 0xA000_0004/0x1234_5678, pready low 5 cycles -> pwdata stable for 6 ACCESS cycles; single r1_rsp_vld with err 0.
- TIMEOUT=4, pready never asserted -> exactly 4 ACCESS cycles, then r0_rsp_err=1, rdata=0, psel=0.
- pslverr=1 with pready -> rsp_err=1; rst_n low mid-ACCESS -> psel/penable drop immediately, no rsp_vld after release, next tie grants r0.
